// File: rtl/ifu_litebpu_pkg.sv
// Shared widths, FSM encodings and BHT counter helpers for the lite branch-prediction unit.
// The optional BHT is built only when IFU_BPU_BHT_EN is defined.
package ifu_litebpu_pkg;
    localparam int XLEN        = 32;
    localparam int PC_SIZE     = 32;
    localparam int RFIDX_WIDTH = 5;

    typedef enum logic [1:0] {
        BPU_S_IDLE = 2'd0,
        BPU_S_REQ  = 2'd1,
        BPU_S_RDY  = 2'd2
    } bpu_state_e;

    localparam logic [1:0] BHT_CNT_RESET = 2'b01;

    // Saturating 2-bit counter step: 0 and 3 are sticky ends.
    function automatic logic [1:0] bht_cnt_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken && cnt != 2'b11)
            res = cnt + 2'b01;
        else if (!taken && cnt != 2'b00)
            res = cnt - 2'b01;
        return res;
    endfunction
endpackage

// File: rtl/ifu_litebpu_bht.sv
// Table of 2-bit saturating counters with a combinational read port and one update port.
// A read and an update of the same entry in one cycle sees the pre-update counter.
module ifu_litebpu_bht
    import ifu_litebpu_pkg::*;
#(
    parameter int BHT_DEPTH = 16,
    localparam int IDX_W = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);
    logic [1:0] cnt_all [BHT_DEPTH];

    // Counters live in flops so the whole table can be cleared by reset.
    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_cnt
            logic [1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (!rst)
                    cnt_reg <= BHT_CNT_RESET;
                else if (upd_valid && upd_idx == IDX_W'(gi))
                    cnt_reg <= bht_cnt_step(cnt_reg, upd_taken);
            end
            assign cnt_all[gi] = cnt_reg;
        end
    endgenerate

    assign rd_taken = cnt_all[rd_idx][1];
endmodule

// File: rtl/ifu_litebpu.sv
// Lite IFU branch predictor: jal/jalr always taken, conditional branches static or BHT predicted.
// Define IFU_BPU_BHT_EN to enable the dynamic branch history table.
module ifu_litebpu
    import ifu_litebpu_pkg::*;
#(
    parameter int BHT_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   dec_i_valid,
    input  logic [PC_SIZE-1:0]     pc,
    input  logic                   dec_bjp,
    input  logic                   dec_jal,
    input  logic                   dec_jalr,
    input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
    input  logic [XLEN-1:0]        dec_bjp_imm,
    input  logic                   oitf_empty,
    input  logic                   ir_empty,
    input  logic                   ir_rs1en,
    input  logic                   ir_rdwen,
    input  logic [RFIDX_WIDTH-1:0] ir_rdidx,
    input  logic [XLEN-1:0]        rf2bpu_x1,
    input  logic [XLEN-1:0]        rf2bpu_rs1,
    input  logic                   upd_valid,
    input  logic [PC_SIZE-1:0]     upd_pc,
    input  logic                   upd_taken,
    output logic                   bpu2rf_rs1_ena,
    output logic                   bpu_wait,
    output logic                   prdt_taken,
    output logic [PC_SIZE-1:0]     prdt_pc
);
    bpu_state_e state_reg;

    logic jalr_x0, jalr_x1, jalr_xn;
    logic x1dep, rs1dep, portbusy;
    logic in_req, grant, bjp_taken;
    logic [XLEN-1:0] op1, target;

    assign jalr_x0 = dec_jalr && dec_jalr_rs1idx == RFIDX_WIDTH'(0);
    assign jalr_x1 = dec_jalr && dec_jalr_rs1idx == RFIDX_WIDTH'(1);
    assign jalr_xn = dec_jalr && !jalr_x0 && !jalr_x1;

    assign x1dep    = !oitf_empty || (!ir_empty && ir_rdwen && ir_rdidx == RFIDX_WIDTH'(1));
    assign rs1dep   = !oitf_empty || (!ir_empty && ir_rdwen && ir_rdidx == dec_jalr_rs1idx);
    assign portbusy = !ir_empty && ir_rs1en;

    // A pending regfile read is in progress either while waiting in REQ or on a fresh jalr in IDLE.
    assign in_req = (state_reg == BPU_S_REQ)
                 || (state_reg == BPU_S_IDLE && dec_i_valid && jalr_xn);
    assign grant  = in_req && !rs1dep && !portbusy;

    assign bpu2rf_rs1_ena = grant && !flush;
    assign bpu_wait       = !flush && (in_req
                         || (state_reg == BPU_S_IDLE && dec_i_valid && jalr_x1 && x1dep));

    always_ff @(posedge clk) begin
        if (!rst)
            state_reg <= BPU_S_IDLE;
        else if (flush)
            state_reg <= BPU_S_IDLE;
        else begin
            case (state_reg)
                BPU_S_IDLE, BPU_S_REQ: begin
                    if (in_req)
                        state_reg <= grant ? BPU_S_RDY : BPU_S_REQ;
                end
                default: state_reg <= BPU_S_IDLE;
            endcase
        end
    end

`ifdef IFU_BPU_BHT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    ifu_litebpu_bht #(
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pc[IDX_W+1:2]),
        .rd_taken  (bjp_taken),
        .upd_valid (upd_valid),
        .upd_idx   (upd_pc[IDX_W+1:2]),
        .upd_taken (upd_taken)
    );

    logic unused_upd_bits;
    assign unused_upd_bits = ^{upd_pc[PC_SIZE-1:IDX_W+2], upd_pc[1:0]};
`else
    // Static scheme: backward branches (negative offset) are predicted taken.
    assign bjp_taken = dec_bjp_imm[XLEN-1];

    logic unused_upd;
    assign unused_upd = ^{upd_valid, upd_pc, upd_taken};
`endif

    always_comb begin
        op1 = XLEN'(pc);
        if (dec_jalr) begin
            if (jalr_x0)
                op1 = '0;
            else if (jalr_x1)
                op1 = rf2bpu_x1;
            else
                op1 = rf2bpu_rs1;
        end
    end

    assign target     = op1 + dec_bjp_imm;
    assign prdt_pc    = target[PC_SIZE-1:0];
    assign prdt_taken = dec_i_valid && !bpu_wait
                     && (dec_jal || dec_jalr || (dec_bjp && bjp_taken));
endmodule

// File: tb/tb_ifu_litebpu.sv
// Directed self-checking bench for ifu_litebpu; BHT scenarios run when IFU_BPU_BHT_EN is defined.
module tb_ifu_litebpu;
    import ifu_litebpu_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   dec_i_valid;
    logic [PC_SIZE-1:0]     pc;
    logic                   dec_bjp, dec_jal, dec_jalr;
    logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx;
    logic [XLEN-1:0]        dec_bjp_imm;
    logic                   oitf_empty, ir_empty, ir_rs1en, ir_rdwen;
    logic [RFIDX_WIDTH-1:0] ir_rdidx;
    logic [XLEN-1:0]        rf2bpu_x1, rf2bpu_rs1;
    logic                   upd_valid;
    logic [PC_SIZE-1:0]     upd_pc;
    logic                   upd_taken;
    logic                   bpu2rf_rs1_ena, bpu_wait, prdt_taken;
    logic [PC_SIZE-1:0]     prdt_pc;

    int n_checks = 0;
    int n_fail   = 0;

    ifu_litebpu dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .dec_i_valid     (dec_i_valid),
        .pc              (pc),
        .dec_bjp         (dec_bjp),
        .dec_jal         (dec_jal),
        .dec_jalr        (dec_jalr),
        .dec_jalr_rs1idx (dec_jalr_rs1idx),
        .dec_bjp_imm     (dec_bjp_imm),
        .oitf_empty      (oitf_empty),
        .ir_empty        (ir_empty),
        .ir_rs1en        (ir_rs1en),
        .ir_rdwen        (ir_rdwen),
        .ir_rdidx        (ir_rdidx),
        .rf2bpu_x1       (rf2bpu_x1),
        .rf2bpu_rs1      (rf2bpu_rs1),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .bpu2rf_rs1_ena  (bpu2rf_rs1_ena),
        .bpu_wait        (bpu_wait),
        .prdt_taken      (prdt_taken),
        .prdt_pc         (prdt_pc)
    );

    always #5 clk = ~clk;

    task automatic quiet_inputs();
        flush = 0; dec_i_valid = 0; pc = '0;
        dec_bjp = 0; dec_jal = 0; dec_jalr = 0; dec_jalr_rs1idx = '0; dec_bjp_imm = '0;
        oitf_empty = 1; ir_empty = 1; ir_rs1en = 0; ir_rdwen = 0; ir_rdidx = '0;
        rf2bpu_x1 = '0; rf2bpu_rs1 = '0;
        upd_valid = 0; upd_pc = '0; upd_taken = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_jalr(input logic [RFIDX_WIDTH-1:0] rs1, input logic [XLEN-1:0] imm);
        dec_i_valid = 1; dec_jalr = 1; dec_jal = 0; dec_bjp = 0;
        dec_jalr_rs1idx = rs1; dec_bjp_imm = imm;
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst = 0;
        next_cycle(); next_cycle();
        rst = 1; #1;
        $display("reset: wait=%0b ena=%0b", bpu_wait, bpu2rf_rs1_ena);
        n_checks++; if (bpu_wait !== 1'b0) begin n_fail++; $display("FAIL reset_wait: got %0b want 0", bpu_wait); end
        n_checks++; if (bpu2rf_rs1_ena !== 1'b0) begin n_fail++; $display("FAIL reset_ena: got %0b want 0", bpu2rf_rs1_ena); end
        n_checks++; if (prdt_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %0b want 0", prdt_taken); end
    endtask

    task automatic test_jal();
        quiet_inputs();
        dec_i_valid = 1; dec_jal = 1; pc = 32'h8000_0000; dec_bjp_imm = 32'h10; #1;
        $display("jal: pc=%h taken=%0b prdt=%h wait=%0b", pc, prdt_taken, prdt_pc, bpu_wait);
        n_checks++; if (prdt_taken !== 1'b1) begin n_fail++; $display("FAIL jal_taken: got %0b want 1", prdt_taken); end
        n_checks++; if (prdt_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL jal_pc: got %h want 80000010", prdt_pc); end
        n_checks++; if (bpu_wait !== 1'b0) begin n_fail++; $display("FAIL jal_wait: got %0b want 0", bpu_wait); end
        pc = 32'hFFFF_FFF0; dec_bjp_imm = 32'h20; #1;
        $display("jal wrap: prdt=%h", prdt_pc);
        n_checks++; if (prdt_pc !== 32'h0000_0010) begin n_fail++; $display("FAIL jal_wrap: got %h want 00000010", prdt_pc); end
        dec_i_valid = 0; #1;
        n_checks++; if (prdt_taken !== 1'b0) begin n_fail++; $display("FAIL jal_invalid: got %0b want 0", prdt_taken); end
        next_cycle();
    endtask

    task automatic test_bjp();
        quiet_inputs();
        dec_i_valid = 1; dec_bjp = 1; pc = 32'h100; dec_bjp_imm = 32'hFFFF_FFF8; #1;
        $display("bjp back: taken=%0b prdt=%h", prdt_taken, prdt_pc);
        n_checks++; if (prdt_pc !== 32'h0000_00F8) begin n_fail++; $display("FAIL bjp_back_pc: got %h want 000000f8", prdt_pc); end
`ifdef IFU_BPU_BHT_EN
        n_checks++; if (prdt_taken !== 1'b0) begin n_fail++; $display("FAIL bjp_back_bht_taken: got %0b want 0", prdt_taken); end
`else
        n_checks++; if (prdt_taken !== 1'b1) begin n_fail++; $display("FAIL bjp_back_taken: got %0b want 1", prdt_taken); end
`endif
        dec_bjp_imm = 32'h8; #1;
        $display("bjp fwd: taken=%0b", prdt_taken);
        n_checks++; if (prdt_taken !== 1'b0) begin n_fail++; $display("FAIL bjp_fwd_taken: got %0b want 0", prdt_taken); end
        next_cycle();
    endtask

    task automatic test_jalr_x0();
        quiet_inputs();
        set_jalr(5'd0, 32'h1234); pc = 32'h4000; rf2bpu_x1 = 32'h5555; rf2bpu_rs1 = 32'h6666; #1;
        $display("jalr x0: taken=%0b prdt=%h wait=%0b", prdt_taken, prdt_pc, bpu_wait);
        n_checks++; if (prdt_pc !== 32'h0000_1234) begin n_fail++; $display("FAIL jalr_x0_pc: got %h want 00001234", prdt_pc); end
        n_checks++; if (prdt_taken !== 1'b1 || bpu_wait !== 1'b0) begin n_fail++; $display("FAIL jalr_x0_flags: got taken=%0b wait=%0b want 1/0", prdt_taken, bpu_wait); end
        next_cycle();
    endtask

    task automatic test_jalr_x1();
        quiet_inputs();
        set_jalr(5'd1, 32'h4); pc = 32'h700; rf2bpu_x1 = 32'h1111;
        ir_empty = 0; ir_rdwen = 1; ir_rdidx = 5'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            $display("jalr x1 hazard cycle %0d: wait=%0b taken=%0b", i, bpu_wait, prdt_taken);
            n_checks++; if (bpu_wait !== 1'b1 || prdt_taken !== 1'b0) begin n_fail++; $display("FAIL jalr_x1_hazard%0d: got wait=%0b taken=%0b want 1/0", i, bpu_wait, prdt_taken); end
            n_checks++; if (bpu2rf_rs1_ena !== 1'b0) begin n_fail++; $display("FAIL jalr_x1_ena%0d: got %0b want 0", i, bpu2rf_rs1_ena); end
            next_cycle();
        end
        ir_empty = 1; ir_rdwen = 0; rf2bpu_x1 = 32'h2000; #1;
        $display("jalr x1 release: wait=%0b prdt=%h", bpu_wait, prdt_pc);
        n_checks++; if (bpu_wait !== 1'b0 || prdt_taken !== 1'b1) begin n_fail++; $display("FAIL jalr_x1_release: got wait=%0b taken=%0b want 0/1", bpu_wait, prdt_taken); end
        n_checks++; if (prdt_pc !== 32'h0000_2004) begin n_fail++; $display("FAIL jalr_x1_pc: got %h want 00002004", prdt_pc); end
        oitf_empty = 0; #1;
        n_checks++; if (bpu_wait !== 1'b1) begin n_fail++; $display("FAIL jalr_x1_oitf: got %0b want 1", bpu_wait); end
        next_cycle();
    endtask

    task automatic test_jalr_rs1();
        quiet_inputs();
        set_jalr(5'd5, 32'hFFFF_FFF8); pc = 32'h900;
        ir_empty = 0; ir_rs1en = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            $display("jalr rs5 busy cycle %0d: wait=%0b ena=%0b", i, bpu_wait, bpu2rf_rs1_ena);
            n_checks++; if (bpu_wait !== 1'b1 || bpu2rf_rs1_ena !== 1'b0) begin n_fail++; $display("FAIL jalr_busy%0d: got wait=%0b ena=%0b want 1/0", i, bpu_wait, bpu2rf_rs1_ena); end
            next_cycle();
        end
        ir_empty = 1; ir_rs1en = 0; #1;
        $display("jalr rs5 grant: wait=%0b ena=%0b", bpu_wait, bpu2rf_rs1_ena);
        n_checks++; if (bpu_wait !== 1'b1 || bpu2rf_rs1_ena !== 1'b1) begin n_fail++; $display("FAIL jalr_grant: got wait=%0b ena=%0b want 1/1", bpu_wait, bpu2rf_rs1_ena); end
        next_cycle();
        rf2bpu_rs1 = 32'h3000; #1;
        $display("jalr rs5 ready: wait=%0b ena=%0b prdt=%h", bpu_wait, bpu2rf_rs1_ena, prdt_pc);
        n_checks++; if (bpu_wait !== 1'b0 || bpu2rf_rs1_ena !== 1'b0) begin n_fail++; $display("FAIL jalr_rdy_flags: got wait=%0b ena=%0b want 0/0", bpu_wait, bpu2rf_rs1_ena); end
        n_checks++; if (prdt_taken !== 1'b1 || prdt_pc !== 32'h0000_2FF8) begin n_fail++; $display("FAIL jalr_rdy_pc: got taken=%0b pc=%h want 1/00002ff8", prdt_taken, prdt_pc); end
        next_cycle();
        dec_i_valid = 0; #1;
        n_checks++; if (bpu_wait !== 1'b0) begin n_fail++; $display("FAIL jalr_back_idle: got %0b want 0", bpu_wait); end
        next_cycle();
    endtask

    task automatic test_flush();
        quiet_inputs();
        set_jalr(5'd5, 32'h10); rf2bpu_rs1 = 32'h500;
        ir_empty = 0; ir_rdwen = 1; ir_rdidx = 5'd5; #1;
        $display("flush c1: wait=%0b ena=%0b", bpu_wait, bpu2rf_rs1_ena);
        n_checks++; if (bpu_wait !== 1'b1 || bpu2rf_rs1_ena !== 1'b0) begin n_fail++; $display("FAIL flush_c1: got wait=%0b ena=%0b want 1/0", bpu_wait, bpu2rf_rs1_ena); end
        next_cycle();
        ir_empty = 1; ir_rdwen = 0; flush = 1; #1;
        $display("flush c2: wait=%0b ena=%0b", bpu_wait, bpu2rf_rs1_ena);
        n_checks++; if (bpu_wait !== 1'b0 || bpu2rf_rs1_ena !== 1'b0) begin n_fail++; $display("FAIL flush_c2: got wait=%0b ena=%0b want 0/0", bpu_wait, bpu2rf_rs1_ena); end
        next_cycle();
        flush = 0; #1;
        $display("flush c3: wait=%0b ena=%0b", bpu_wait, bpu2rf_rs1_ena);
        n_checks++; if (bpu_wait !== 1'b1 || bpu2rf_rs1_ena !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got wait=%0b ena=%0b want 1/1", bpu_wait, bpu2rf_rs1_ena); end
        next_cycle();
        #1;
        n_checks++; if (prdt_pc !== 32'h0000_0510 || bpu_wait !== 1'b0) begin n_fail++; $display("FAIL flush_rdy: got pc=%h wait=%0b want 00000510/0", prdt_pc, bpu_wait); end
        dec_i_valid = 0;
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        quiet_inputs();
        set_jalr(5'd7, 32'h0); ir_empty = 0; ir_rs1en = 1;
        next_cycle();
        rst = 0;
        next_cycle();
        rst = 1; dec_i_valid = 0; #1;
        $display("reset mid-wait: wait=%0b ena=%0b", bpu_wait, bpu2rf_rs1_ena);
        n_checks++; if (bpu_wait !== 1'b0 || bpu2rf_rs1_ena !== 1'b0) begin n_fail++; $display("FAIL reset_mid_wait: got wait=%0b ena=%0b want 0/0", bpu_wait, bpu2rf_rs1_ena); end
        next_cycle();
    endtask

`ifdef IFU_BPU_BHT_EN
    task automatic test_bht();
        quiet_inputs();
        dec_i_valid = 1; dec_bjp = 1; pc = 32'h80; dec_bjp_imm = 32'h8; #1;
        n_checks++; if (prdt_taken !== 1'b0) begin n_fail++; $display("FAIL bht_init: got %0b want 0", prdt_taken); end
        dec_i_valid = 0;
        upd_valid = 1; upd_pc = 32'h40; upd_taken = 1;
        next_cycle(); next_cycle();
        upd_valid = 0; dec_i_valid = 1; #1;
        $display("bht after 2 taken: taken=%0b prdt=%h", prdt_taken, prdt_pc);
        n_checks++; if (prdt_taken !== 1'b1 || prdt_pc !== 32'h88) begin n_fail++; $display("FAIL bht_trained: got taken=%0b pc=%h want 1/00000088", prdt_taken, prdt_pc); end
        upd_valid = 1; upd_taken = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            $display("bht same-cycle update %0d: taken=%0b", i, prdt_taken);
            n_checks++; if (prdt_taken !== 1'b1) begin n_fail++; $display("FAIL bht_old_value%0d: got %0b want 1", i, prdt_taken); end
            next_cycle();
        end
        upd_valid = 0; #1;
        n_checks++; if (prdt_taken !== 1'b0) begin n_fail++; $display("FAIL bht_decayed: got %0b want 0", prdt_taken); end
        dec_i_valid = 0;
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_jal();
        test_bjp();
        test_jalr_x0();
        test_jalr_x1();
        test_jalr_rs1();
        test_flush();
        test_reset_mid_wait();
`ifdef IFU_BPU_BHT_EN
        test_bht();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
